// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU arbiter and anything that talks to the ALU:
//   - flag bit positions inside the 4-bit flag vector
//   - opcode encodings (the arbiter never decodes them, the ALU does)
//   - arbiter FSM state encoding
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int FLAG_W        = 4;
    localparam int FLAG_ERR      = 0;
    localparam int FLAG_NEG      = 1;
    localparam int FLAG_POS      = 2;
    localparam int FLAG_OVERFLOW = 3;

    localparam logic [1:0] SUB           = 2'b00;
    localparam logic [1:0] NAND          = 2'b01;
    localparam logic [1:0] STARTING_ONES = 2'b10;
    localparam logic [1:0] ONEHOT_DEC    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant, purely combinational.
// Ports:
//   request[1:0] : per-requester request
//   last_grant   : index of the requester granted most recently
//   grant[1:0]   : one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic [1:0] request,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (request)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie: favour whoever did not win last time.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external ALU between two requesters. A granted request's
// operands are registered onto the ALU bus, the result is captured after
// ALU_LAT edges and held as a response until the served requester accepts.
// Ports:
//   i_clk, i_rstn                : clock, synchronous active-low reset
//   i_req_valid/o_req_ready      : per-requester request handshake
//   i_req_arg0/arg1/oper         : packed per-requester operands/opcode
//   o_rsp_valid/i_rsp_ready      : one-hot response handshake
//   o_rsp_result/o_rsp_flag      : captured ALU result and flags
//   o_alu_arg0/arg1/oper         : registered drive to the shared ALU
//   i_alu_result/i_alu_flag      : ALU outputs
//   o_busy                       : high whenever not IDLE
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LEN     = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [1:0]           i_req_valid,
    output logic [1:0]           o_req_ready,
    input  logic [2*WIDTH-1:0]   i_req_arg0,
    input  logic [2*WIDTH-1:0]   i_req_arg1,
    input  logic [2*LEN-1:0]     i_req_oper,
    output logic [1:0]           o_rsp_valid,
    input  logic [1:0]           i_rsp_ready,
    output logic [WIDTH-1:0]     o_rsp_result,
    output logic [FLAG_W-1:0]    o_rsp_flag,
    output logic [WIDTH-1:0]     o_alu_arg0,
    output logic [WIDTH-1:0]     o_alu_arg1,
    output logic [LEN-1:0]       o_alu_oper,
    input  logic [WIDTH-1:0]     i_alu_result,
    input  logic [FLAG_W-1:0]    i_alu_flag,
    output logic                 o_busy
);

    localparam int               CNT_W    = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT);

    state_t            state_reg, state_next;
    logic              last_grant_reg;
    logic [1:0]        served_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [1:0]        grant;
    logic              grant_idx;
    logic              accept;
    logic              rsp_done;

    // Unpack per-requester operand slices.
    logic [WIDTH-1:0]  arg0_arr [2];
    logic [WIDTH-1:0]  arg1_arr [2];
    logic [LEN-1:0]    oper_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slice
            assign arg0_arr[gi] = i_req_arg0[gi*WIDTH +: WIDTH];
            assign arg1_arr[gi] = i_req_arg1[gi*WIDTH +: WIDTH];
            assign oper_arr[gi] = i_req_oper[gi*LEN +: LEN];
        end
    endgenerate

    rr_arbiter2 u_rr (
        .request    (i_req_valid),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    assign grant_idx = grant[1];
    assign accept    = (state_reg == ST_IDLE) && (|grant);
    // Only the served requester's ready bit can close the response.
    assign rsp_done  = (state_reg == ST_RESP) && (|(served_reg & i_rsp_ready));

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)          state_next = ST_EXEC;
            ST_EXEC: if (cnt_reg == '0)   state_next = ST_RESP;
            ST_RESP: if (rsp_done)        state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    // Outputs derived from state
    always_comb begin
        o_busy      = (state_reg != ST_IDLE);
        o_rsp_valid = (state_reg == ST_RESP) ? served_reg : 2'b00;
        o_req_ready = ((state_reg == ST_IDLE) && i_rstn) ? grant : 2'b00;
    end

    // Datapath: ALU operand register, latency counter, response capture.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            last_grant_reg <= 1'b1;
            served_reg     <= 2'b00;
            cnt_reg        <= '0;
            o_alu_arg0     <= '0;
            o_alu_arg1     <= '0;
            o_alu_oper     <= '0;
            o_rsp_result   <= '0;
            o_rsp_flag     <= '0;
        end else begin
            if (accept) begin
                o_alu_arg0     <= arg0_arr[grant_idx];
                o_alu_arg1     <= arg1_arr[grant_idx];
                o_alu_oper     <= oper_arr[grant_idx];
                cnt_reg        <= CNT_LOAD;
                served_reg     <= grant;
                last_grant_reg <= grant_idx;
            end
            if (state_reg == ST_EXEC) begin
                if (cnt_reg == '0) begin
                    o_rsp_result <= i_alu_result;
                    o_rsp_flag   <= i_alu_flag;
                end else begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed and randomised checks of alu_arbiter with a registered
// (one-edge latency) reference ALU attached to the ALU bus.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [1:0]  i_req_valid;
    logic [1:0]  o_req_ready;
    logic [7:0]  i_req_arg0, i_req_arg1;
    logic [3:0]  i_req_oper;
    logic [1:0]  o_rsp_valid;
    logic [1:0]  i_rsp_ready;
    logic [3:0]  o_rsp_result;
    logic [3:0]  o_rsp_flag;
    logic [3:0]  o_alu_arg0, o_alu_arg1;
    logic [1:0]  o_alu_oper;
    logic [3:0]  i_alu_result = 4'd0;
    logic [3:0]  i_alu_flag   = 4'd0;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] a0_q [2];
    logic [3:0] a1_q [2];
    logic [1:0] op_q [2];
    logic [1:0] vld;

    always #5 i_clk = ~i_clk;

    alu_arbiter #(.WIDTH(4), .LEN(2), .ALU_LAT(1)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_arg0   (i_req_arg0),
        .i_req_arg1   (i_req_arg1),
        .i_req_oper   (i_req_oper),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_result (o_rsp_result),
        .o_rsp_flag   (o_rsp_flag),
        .o_alu_arg0   (o_alu_arg0),
        .o_alu_arg1   (o_alu_arg1),
        .o_alu_oper   (o_alu_oper),
        .i_alu_result (i_alu_result),
        .i_alu_flag   (i_alu_flag),
        .o_busy       (o_busy)
    );

    // Reference ALU: returns {flag, result}. Flags: err=0, neg=1, pos=2, ovf=3.
    function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic       err, ovf;
        int         n;
        r = 4'd0; err = 1'b0; ovf = 1'b0;
        case (op)
            2'b00: begin
                r   = a - b;
                ovf = (a[3] != b[3]) && (r[3] != a[3]);
            end
            2'b01: r = ~(a & b);
            2'b10: begin
                n = 0;
                for (int i = 3; i >= 0; i--) begin
                    if (a[i] && n == 3 - i) n++;
                end
                r = 4'(n);
            end
            default: begin
                case (a)
                    4'b0001: r = 4'd0;
                    4'b0010: r = 4'd1;
                    4'b0100: r = 4'd2;
                    4'b1000: r = 4'd3;
                    default: err = 1'b1;
                endcase
            end
        endcase
        if (err) return {4'b0001, 4'd0};
        return {ovf, (!r[3] && r != 4'd0), r[3], 1'b0, r};
    endfunction

    // ALU with one edge of latency.
    always @(posedge i_clk) begin
        {i_alu_flag, i_alu_result} <= alu_ref(o_alu_oper, o_alu_arg0, o_alu_arg1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive();
        i_req_arg0  = {a0_q[1], a0_q[0]};
        i_req_arg1  = {a1_q[1], a1_q[0]};
        i_req_oper  = {op_q[1], op_q[0]};
        i_req_valid = vld;
    endtask

    task automatic set_req(input int g, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        a0_q[g] = a; a1_q[g] = b; op_q[g] = op;
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        step();
        i_rstn = 1'b1;
    endtask

    logic [1:0] pend;
    logic       last_g;
    int         exp_g;
    logic [7:0] exp_rsp;
    logic [3:0] held_res;
    int         done, n, dly;

    initial begin
        vld = 2'b00; i_rsp_ready = 2'b00; i_rstn = 1'b0;
        for (int g = 0; g < 2; g++) set_req(g, 4'd0, 4'd0, 2'b00);
        drive();
        step(); step();

        // Reset state; ready gated by reset even with requests present.
        vld = 2'b11; drive(); #1;
        chk("rst_ready", o_req_ready, 2'b00);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_rsp_valid", o_rsp_valid, 2'b00);
        chk("rst_result", o_rsp_result, 4'd0);
        chk("rst_flag", o_rsp_flag, 4'd0);
        chk("rst_alu_arg0", o_alu_arg0, 4'd0);
        vld = 2'b00; drive();
        i_rstn = 1'b1;
        step();

        // Single SUB from requester 0.
        set_req(0, 4'b0101, 4'b0011, 2'b00); vld = 2'b01; drive(); #1;
        chk("sub_ready", o_req_ready, 2'b01);
        step();                                   // E0
        vld = 2'b00; drive(); #1;
        chk("sub_busy", o_busy, 1'b1);
        chk("sub_alu_arg0", o_alu_arg0, 4'b0101);
        chk("sub_alu_arg1", o_alu_arg1, 4'b0011);
        chk("sub_rsp_early0", o_rsp_valid, 2'b00);
        step();                                   // E0+1
        chk("sub_rsp_early1", o_rsp_valid, 2'b00);
        step();                                   // E0+2
        chk("sub_rsp_valid", o_rsp_valid, 2'b01);
        chk("sub_result", o_rsp_result, 4'b0010);
        chk("sub_flag", o_rsp_flag, 4'b0100);
        i_rsp_ready = 2'b01;
        step();
        i_rsp_ready = 2'b00;
        chk("sub_done_busy", o_busy, 1'b0);
        chk("sub_done_rsp", o_rsp_valid, 2'b00);

        // Tie after reset: req0 first, then req1, with backpressure on req1.
        do_reset();
        set_req(0, 4'b1111, 4'b0000, 2'b01);
        set_req(1, 4'b1100, 4'b0011, 2'b10);
        vld = 2'b11; drive(); #1;
        chk("tie_ready0", o_req_ready, 2'b01);
        step(); step(); step();
        chk("nand_rsp_valid", o_rsp_valid, 2'b01);
        chk("nand_result", o_rsp_result, 4'b1111);
        chk("nand_flag", o_rsp_flag, 4'b0010);
        i_rsp_ready = 2'b11;
        step();
        i_rsp_ready = 2'b00;
        chk("tie_ready1", o_req_ready, 2'b10);
        step(); step(); step();
        chk("so_rsp_valid", o_rsp_valid, 2'b10);
        chk("so_result", o_rsp_result, 4'b0010);
        chk("so_flag", o_rsp_flag, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_rsp_valid", o_rsp_valid, 2'b10);
            chk("bp_result", o_rsp_result, 4'b0010);
            chk("bp_flag", o_rsp_flag, 4'b0100);
            chk("bp_req_ready", o_req_ready, 2'b00);
        end
        i_rsp_ready = 2'b01;                      // wrong requester: ignored
        step();
        chk("bp_other_ready", o_rsp_valid, 2'b10);
        i_rsp_ready = 2'b10;
        step();
        i_rsp_ready = 2'b00;
        chk("tie_next_req0", o_req_ready, 2'b01);
        vld = 2'b00; drive();                     // withdrawn before an edge
        step();
        chk("withdraw_busy", o_busy, 1'b0);

        // Reset during EXEC aborts the operation.
        set_req(0, 4'b0111, 4'b0001, 2'b00); vld = 2'b01; drive();
        step();
        vld = 2'b00; drive();
        chk("abort_busy_pre", o_busy, 1'b1);
        do_reset();
        chk("abort_busy", o_busy, 1'b0);
        chk("abort_rsp_valid", o_rsp_valid, 2'b00);
        chk("abort_result", o_rsp_result, 4'd0);
        chk("abort_flag", o_rsp_flag, 4'd0);
        chk("abort_alu_arg0", o_alu_arg0, 4'd0);
        chk("abort_alu_oper", o_alu_oper, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_rsp", o_rsp_valid, 2'b00);
        end

        // Handshake coincides with a new req1: one-cycle bubble.
        set_req(0, 4'b0101, 4'b0011, 2'b00); vld = 2'b01; drive();
        step();
        vld = 2'b00; drive();
        step(); step();
        chk("bub_rsp_valid", o_rsp_valid, 2'b01);
        set_req(1, 4'b0010, 4'b1000, 2'b11); vld = 2'b10; i_rsp_ready = 2'b01; drive(); #1;
        chk("bub_ready_in_resp", o_req_ready, 2'b00);
        step();
        i_rsp_ready = 2'b00;
        chk("bub_busy", o_busy, 1'b0);
        chk("bub_ready_next", o_req_ready, 2'b10);
        step();
        vld = 2'b00; drive();
        chk("bub_alu_arg0", o_alu_arg0, 4'b0010);
        chk("bub_alu_oper", o_alu_oper, 2'b11);
        step(); step();
        chk("ohd_rsp_valid", o_rsp_valid, 2'b10);
        chk("ohd_result", o_rsp_result, 4'b0001);
        chk("ohd_flag", o_rsp_flag, 4'b0100);
        i_rsp_ready = 2'b10;
        step();
        i_rsp_ready = 2'b00;

        // Randomised run against the reference ALU and round-robin model.
        pend = 2'b00; last_g = 1'b1; done = 0;
        while (done < 50) begin
            for (int g = 0; g < 2; g++) begin
                if (!pend[g] && $urandom_range(0, 1) == 1) begin
                    pend[g] = 1'b1;
                    set_req(g, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                            2'($urandom_range(0, 3)));
                end
            end
            vld = pend; drive(); #1;
            if (pend == 2'b00) begin
                step();
                continue;
            end
            exp_g = (pend == 2'b11) ? (last_g ? 0 : 1) : (pend[1] ? 1 : 0);
            chk("rnd_ready", o_req_ready, 32'(1 << exp_g));
            exp_rsp = alu_ref(op_q[exp_g], a0_q[exp_g], a1_q[exp_g]);
            step();
            pend[exp_g] = 1'b0; last_g = exp_g[0];
            vld = pend; drive();
            n = 0;
            while (o_rsp_valid == 2'b00 && n < 8) begin
                step();
                n++;
            end
            chk("rnd_rsp_valid", o_rsp_valid, 32'(1 << exp_g));
            chk("rnd_result", o_rsp_result, exp_rsp[3:0]);
            chk("rnd_flag", o_rsp_flag, exp_rsp[7:4]);
            held_res = o_rsp_result;
            dly = $urandom_range(0, 2);
            for (int i = 0; i < dly; i++) begin
                step();
                chk("rnd_hold", o_rsp_result, held_res);
            end
            i_rsp_ready = 2'(1 << exp_g);
            step();
            i_rsp_ready = 2'b00;
            $display("op %0d: req%0d result=%0h flag=%0h", done, exp_g, exp_rsp[3:0], exp_rsp[7:4]);
            done++;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits.
REQ-002 Parameter LEN, default 2, operation-code width in bits.
REQ-003 Parameter ALU_LAT, default 1, number of clock edges from ALU operand presentation to a valid ALU result (0 = combinational ALU).
REQ-004 The block SHALL use one clock and a synchronous, active-low reset.
REQ-005 i_clk  in  1  clock; all state changes on its rising edge.
REQ-006 i_rstn  in  1  synchronous, active-low reset.
REQ-007 i_req_valid  in  2  per-requester request valid; bit g belongs to requester g.
REQ-008 o_req_ready  out  2  per-requester accept strobe.
REQ-009 i_req_arg0, i_req_arg1  in  2*WIDTH each  operands; requester g owns slice [g*WIDTH +: WIDTH].
REQ-010 i_req_oper  in  2*LEN  opcode; requester g owns slice [g*LEN +: LEN].
REQ-011 o_rsp_valid  out  2  one-hot response valid for the requester being served.
REQ-012 i_rsp_ready  in  2  per-requester response accept.
REQ-013 o_rsp_result  out  WIDTH and o_rsp_flag  out  4  captured ALU result and flags (err, neg, pos, overflow at bits 0..3).
REQ-014 o_alu_arg0, o_alu_arg1  out  WIDTH and o_alu_oper  out  LEN  drive the shared ALU.
REQ-015 i_alu_result  in  WIDTH and i_alu_flag  in  4  ALU outputs.
REQ-016 o_busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-018 In IDLE with any i_req_valid bit set, the block SHALL grant one requester; on a tie it SHALL grant the requester not equal to last_grant (round-robin).
REQ-019 o_req_ready[g] SHALL be combinational: 1 only when the state is IDLE, i_rstn=1 and g is granted; the other bit is 0.
REQ-020 On the accept edge E0, the block SHALL register the granted operands and opcode onto o_alu_*, load a counter with ALU_LAT, record the grant, update last_grant and enter EXEC.
REQ-021 o_alu_* SHALL hold stable from E0 until the next accept.
REQ-022 In EXEC the counter SHALL decrement each edge; on the edge where it equals 0, the block SHALL capture i_alu_result and i_alu_flag into o_rsp_result and o_rsp_flag and enter RESP.
REQ-023 o_rsp_valid SHALL therefore become visible after edge E0+ALU_LAT+1 (edge E0+2 for ALU_LAT=1).
REQ-024 In RESP, o_rsp_valid[g] SHALL stay high with stable result and flag until i_rsp_ready[g]=1 on an edge, after which the state returns to IDLE.
REQ-025 i_rsp_ready of the non-served requester SHALL be ignored.
REQ-026 While not in IDLE, all requests SHALL be held off (o_req_ready=0).
REQ-027 A pending request arriving in the same cycle as the response handshake SHALL be accepted no earlier than the following cycle (one-cycle bubble).
REQ-028 The block SHALL pass results and flags through unmodified and SHALL NOT interpret the opcode.
REQ-029 A requester dropping valid before ready SHALL have no effect: only a valid&ready edge starts an operation.

Reset
REQ-030 A reset edge with i_rstn=0 SHALL force IDLE, last_grant=1 (requester 0 wins the first tie), counter=0 and o_busy=0.
REQ-031 The same reset edge SHALL force o_rsp_valid=0, o_rsp_result=0, o_rsp_flag=0 and o_alu_*=0; o_req_ready SHALL be 0 while i_rstn=0.
REQ-032 A reset during EXEC or RESP SHALL abort the operation with no response and no later spurious o_rsp_valid.

Structure
REQ-033 Shared package alu_pkg SHALL hold the flag bit positions (FLAG_ERR=0, FLAG_NEG=1, FLAG_POS=2, FLAG_OVERFLOW=3), the opcode constants (SUB=00, NAND=01, STARTING_ONES=10, ONEHOT_DEC=11) and the FSM state encoding.
REQ-034 The two-way round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs: request[1:0], last_grant; output: one-hot grant).

Verification (bench instantiates TOP with WIDTH=4, LEN=2 as the ALU, ALU_LAT=1)
REQ-035 Req0 only, arg0=0101, arg1=0011, oper=00 -> ready0 at E0; rsp_valid=01 after E0+2; result 0010, flag POS.
REQ-036 Both valid after reset: req0 nand 1111/0000, req1 oper=10 1100/0011 -> req0 served first, then req1; next tie goes to req0.
REQ-037 Response backpressure: i_rsp_ready held 0 for 5 cycles -> rsp_valid and result stable; o_req_ready=00 throughout.
REQ-038 Reset asserted during EXEC -> after the reset edge, IDLE with all outputs 0; no response for the aborted request.
REQ-039 Response handshake coinciding with req1 valid (oper=11, 0010/1000) -> accepted exactly one cycle later; result matches the TOP output.
REQ-040 Random 50-operation run with both requesters -> every response matches a reference model, and no requester starves beyond one intervening grant.
